// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with valid/ready handshakes.
// Channel chosen by external select (MODE=0) or round-robin arbitration (MODE=1).
module stream_mux_rr #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = 0,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
);

    localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]   LP_NCH  = (SEL_W + 1)'(N_CH);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [SEL_W-1:0]  r_ch;
    logic [SEL_W-1:0]  r_ptr;

    logic [DATA_W-1:0] w_ch_data [N_CH];
    logic              w_load_ok;
    logic              w_grant_vld;
    logic [SEL_W-1:0]  w_grant;
    logic              w_in_xfer;

    for (genvar i = 0; i < N_CH; i++) begin : g_split
        assign w_ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    // The output register can take a new beat when empty or draining this cycle.
    assign w_load_ok = !r_valid || out_ready;

    always_comb begin
        logic [SEL_W-1:0] v_idx;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        v_idx       = r_ptr;
        if (N_CH == 1) begin
            w_grant_vld = (MODE == 0) ? 1'b1 : in_valid[0];
        end else if (MODE == 0) begin
            w_grant_vld = ({1'b0, sel} < LP_NCH);
            w_grant     = sel;
        end else begin
            // Scan from the pointer with wrap; first valid channel wins.
            for (int k = 0; k < N_CH; k++) begin
                if (!w_grant_vld && in_valid[v_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = v_idx;
                end
                v_idx = (v_idx == LP_LAST) ? '0 : v_idx + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (w_grant_vld && w_load_ok) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    assign w_in_xfer = |(in_ready & in_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_in_xfer) begin
                r_data  <= w_ch_data[w_grant];
                r_ch    <= w_grant;
                r_valid <= 1'b1;
                if (MODE == 1) begin
                    r_ptr <= (w_grant == LP_LAST) ? '0 : w_grant + 1'b1;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: select mode (4 and 3 channels) and round-robin mode.
// Inputs change and outputs are sampled on the falling edge.
module tb_stream_mux_rr;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_in_data, b_in_data;
    logic [23:0] c_in_data;
    logic [3:0]  a_in_valid, a_in_ready, b_in_valid, b_in_ready;
    logic [2:0]  c_in_valid, c_in_ready;
    logic [1:0]  a_sel, b_sel, c_sel, a_out_ch, b_out_ch, c_out_ch;
    logic [7:0]  a_out_data, b_out_data, c_out_data;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic        a_out_ready, b_out_ready, c_out_ready;

    stream_mux_rr #(.N_CH(4), .DATA_W(8), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch));

    stream_mux_rr #(.N_CH(4), .DATA_W(8), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch));

    stream_mux_rr #(.N_CH(3), .DATA_W(8), .MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ch(c_out_ch));

    beat_t sb_a[$];
    beat_t sb_b[$];
    beat_t sb_c[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic test_reset();
        a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b1;
        c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({a_out_valid, a_out_data, a_out_ch} !== 11'd0) $display("FAIL reset_a got %h want 0", {a_out_valid, a_out_data, a_out_ch});
        else n_pass++;
        n_total++;
        if ({b_out_valid, b_out_data, b_out_ch} !== 11'd0) $display("FAIL reset_b got %h want 0", {b_out_valid, b_out_data, b_out_ch});
        else n_pass++;
        n_total++;
        if (c_out_valid !== 1'b0) $display("FAIL reset_c_valid got %b want 0", c_out_valid);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sel();
        beat_t e;
        logic  exp_v;
        a_sel = 2'd2; a_in_data = 32'h00A5_0000; a_in_valid = 4'b0100; a_out_ready = 1'b1;
        #1;
        n_total++;
        if (a_in_ready !== 4'b0100) $display("FAIL sel_ready got %b want 0100", a_in_ready);
        else n_pass++;
        sb_a.push_back('{ch: 2'd2, data: 8'hA5});
        @(negedge clk);
        a_in_valid = '0;
        n_total++;
        if (a_out_valid !== 1'b1 || sb_a.size() == 0) $display("FAIL sel_first_valid got %b want 1", a_out_valid);
        else begin
            e = sb_a.pop_front();
            if (a_out_data !== e.data || a_out_ch !== e.ch) $display("FAIL sel_first_beat got %h/%0d want %h/%0d", a_out_data, a_out_ch, e.data, e.ch);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            a_sel = 2'(i % 4);
            a_in_data = $urandom;
            a_in_valid = 4'($urandom_range(0, 15));
            #1;
            n_total++;
            if (a_in_ready !== (4'b0001 << a_sel)) $display("FAIL sel_b2b_ready got %b want %b", a_in_ready, 4'b0001 << a_sel);
            else n_pass++;
            exp_v = a_in_valid[a_sel];
            if (exp_v) sb_a.push_back('{ch: a_sel, data: a_in_data[a_sel*8 +: 8]});
            @(negedge clk);
            n_total++;
            if (a_out_valid !== exp_v) $display("FAIL sel_b2b_valid got %b want %b", a_out_valid, exp_v);
            else if (exp_v) begin
                e = sb_a.pop_front();
                if (a_out_data !== e.data || a_out_ch !== e.ch) $display("FAIL sel_b2b_beat got %h/%0d want %h/%0d", a_out_data, a_out_ch, e.data, e.ch);
                else n_pass++;
            end else n_pass++;
        end
        a_in_valid = '0;
        @(negedge clk);
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL sel_drain got %b want 0", a_out_valid);
        else n_pass++;
    endtask

    task automatic test_rr_rotate();
        beat_t e;
        logic [1:0] g;
        b_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            g = 2'(i % 4);
            b_in_data = $urandom;
            b_in_valid = 4'b1111;
            #1;
            n_total++;
            if (b_in_ready !== (4'b0001 << g)) $display("FAIL rr_ready got %b want %b", b_in_ready, 4'b0001 << g);
            else n_pass++;
            sb_b.push_back('{ch: g, data: b_in_data[g*8 +: 8]});
            @(negedge clk);
            n_total++;
            if (b_out_valid !== 1'b1 || sb_b.size() == 0) $display("FAIL rr_valid got %b want 1", b_out_valid);
            else begin
                e = sb_b.pop_front();
                if (b_out_data !== e.data || b_out_ch !== e.ch) $display("FAIL rr_beat got %h/%0d want %h/%0d", b_out_data, b_out_ch, e.data, e.ch);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rr_skip();
        beat_t e;
        logic [3:0] vld_seq [3] = '{4'b0001, 4'b1001, 4'b1001};
        logic [1:0] exp_g   [3] = '{2'd0, 2'd3, 2'd0};
        for (int i = 0; i < 3; i++) begin
            b_in_data = $urandom;
            b_in_valid = vld_seq[i];
            #1;
            n_total++;
            if (b_in_ready !== (4'b0001 << exp_g[i])) $display("FAIL skip_ready step %0d got %b want %b", i, b_in_ready, 4'b0001 << exp_g[i]);
            else n_pass++;
            sb_b.push_back('{ch: exp_g[i], data: b_in_data[exp_g[i]*8 +: 8]});
            @(negedge clk);
            n_total++;
            if (b_out_valid !== 1'b1 || sb_b.size() == 0) $display("FAIL skip_valid step %0d got %b want 1", i, b_out_valid);
            else begin
                e = sb_b.pop_front();
                if (b_out_data !== e.data || b_out_ch !== e.ch) $display("FAIL skip_beat got %h/%0d want %h/%0d", b_out_data, b_out_ch, e.data, e.ch);
                else n_pass++;
            end
        end
        b_in_valid = '0;
        #1;
        n_total++;
        if (b_in_ready !== 4'b0000) $display("FAIL idle_ready got %b want 0000", b_in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (b_out_valid !== 1'b0) $display("FAIL idle_valid got %b want 0", b_out_valid);
        else n_pass++;
    endtask

    // Pointer is 1 on entry; stall must not move it.
    task automatic test_stall();
        beat_t e;
        b_in_data = $urandom; b_in_valid = 4'b1111; b_out_ready = 1'b1;
        sb_b.push_back('{ch: 2'd1, data: b_in_data[15:8]});
        @(negedge clk);
        b_out_ready = 1'b0;
        b_in_data = $urandom;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (b_in_ready !== 4'b0000) $display("FAIL stall_ready cyc %0d got %b want 0000", i, b_in_ready);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (b_out_valid !== 1'b1 || sb_b.size() == 0) $display("FAIL stall_valid cyc %0d got %b want 1", i, b_out_valid);
            else if (b_out_data !== sb_b[0].data || b_out_ch !== sb_b[0].ch) $display("FAIL stall_hold got %h/%0d want %h/%0d", b_out_data, b_out_ch, sb_b[0].data, sb_b[0].ch);
            else n_pass++;
        end
        b_out_ready = 1'b1;
        b_in_valid = '0;
        @(negedge clk);
        if (sb_b.size() != 0) e = sb_b.pop_front();
        n_total++;
        if (b_out_valid !== 1'b0) $display("FAIL stall_release_once got %b want 0", b_out_valid);
        else n_pass++;
        b_in_data = $urandom; b_in_valid = 4'b1111;
        #1;
        n_total++;
        if (b_in_ready !== 4'b0100) $display("FAIL stall_ptr_held got %b want 0100", b_in_ready);
        else n_pass++;
        sb_b.push_back('{ch: 2'd2, data: b_in_data[23:16]});
        @(negedge clk);
        n_total++;
        if (b_out_valid !== 1'b1 || sb_b.size() == 0) $display("FAIL stall_next_valid got %b want 1", b_out_valid);
        else begin
            e = sb_b.pop_front();
            if (b_out_data !== e.data || b_out_ch !== e.ch) $display("FAIL stall_next_beat got %h/%0d want %h/%0d", b_out_data, b_out_ch, e.data, e.ch);
            else n_pass++;
        end
    endtask

    task automatic test_bad_sel();
        beat_t e;
        c_sel = 2'd3; c_in_data = $urandom; c_in_valid = 3'b111; c_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (c_in_ready !== 3'b000) $display("FAIL badsel_ready got %b want 000", c_in_ready);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (c_out_valid !== 1'b0) $display("FAIL badsel_valid got %b want 0", c_out_valid);
            else n_pass++;
        end
        c_sel = 2'd1;
        #1;
        n_total++;
        if (c_in_ready !== 3'b010) $display("FAIL goodsel_ready got %b want 010", c_in_ready);
        else n_pass++;
        sb_c.push_back('{ch: 2'd1, data: c_in_data[15:8]});
        @(negedge clk);
        c_in_valid = '0;
        n_total++;
        if (c_out_valid !== 1'b1 || sb_c.size() == 0) $display("FAIL goodsel_valid got %b want 1", c_out_valid);
        else begin
            e = sb_c.pop_front();
            if (c_out_data !== e.data || c_out_ch !== e.ch) $display("FAIL goodsel_beat got %h/%0d want %h/%0d", c_out_data, c_out_ch, e.data, e.ch);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        beat_t e;
        b_out_ready = 1'b0; b_in_valid = '0;
        @(negedge clk);
        n_total++;
        if (b_out_valid !== 1'b1) $display("FAIL midrst_pre got %b want 1", b_out_valid);
        else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        sb_b.delete();
        n_total++;
        if ({b_out_valid, b_out_data, b_out_ch} !== 11'd0) $display("FAIL midrst_clear got %h want 0", {b_out_valid, b_out_data, b_out_ch});
        else n_pass++;
        rst_n = 1'b1; b_out_ready = 1'b1;
        b_in_data = $urandom; b_in_valid = 4'b0110;
        #1;
        n_total++;
        if (b_in_ready !== 4'b0010) $display("FAIL midrst_grant got %b want 0010", b_in_ready);
        else n_pass++;
        sb_b.push_back('{ch: 2'd1, data: b_in_data[15:8]});
        @(negedge clk);
        b_in_valid = '0;
        n_total++;
        if (b_out_valid !== 1'b1 || sb_b.size() == 0) $display("FAIL midrst_valid got %b want 1", b_out_valid);
        else begin
            e = sb_b.pop_front();
            if (b_out_data !== e.data || b_out_ch !== e.ch) $display("FAIL midrst_beat got %h/%0d want %h/%0d", b_out_data, b_out_ch, e.data, e.ch);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sel();
        test_rr_rotate();
        test_rr_skip();
        test_stall();
        test_bad_sel();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
